// File: rtl/inst_fetch_sram_pkg.sv
// Shared fetch-side definitions: enable levels, bus widths and the NOP word.
// No logic, so no latency.
// No backpressure; widths and constants only.
package inst_fetch_sram_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    localparam int INST_ADDR_W      = 32;
    localparam int INST_W           = 32;
    localparam int INST_SRAM_ADDR_W = 20;

    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_sram.sv
// Instruction-fetch responder: runs multi-cycle SRAM reads, with a one-entry last-word tag.
// Latency: a hit returns the word in the same cycle; a miss costs WAIT_CYCLES+1 stall cycles.
// Backpressure: stallreq freezes the PC while the word is missing; bus_busy delays a launch.
module inst_fetch_sram
    import inst_fetch_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = INST_SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   ce_i,
    input  logic                   bus_busy_i,
    output logic [INST_W-1:0]      inst_o,
    output logic                   stallreq_o,
    output logic                   if_busy_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    input  logic [INST_W-1:0]      ram_data_i,
    output logic                   ram_ce_n_o,
    output logic                   ram_oe_n_o,
    output logic                   ram_we_n_o,
    output logic [3:0]             ram_be_n_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   cnt_q;
    logic [29:0]  req_addr_q;
    logic [29:0]  tag_q;
    logic [31:0]  data_q;
    logic         valid_q;

    logic [29:0]  pc_word;
    logic         hit;
    logic         launch;
    logic         done;
    logic [1:0]   unused_byte_offset;

    // Byte offset within the word never affects which word is fetched.
    assign pc_word            = pc_i[31:2];
    assign unused_byte_offset = pc_i[1:0];

    assign hit    = (ce_i == CHIP_ENABLE) & valid_q & (tag_q == pc_word);
    assign launch = (state_q == S_IDLE) & (ce_i == CHIP_ENABLE) & ~hit & ~bus_busy_i;
    assign done   = (state_q == S_WAIT) & (cnt_q == 4'd0);

    // A miss (or disabled fetch) returns a zero word, which the pipeline treats as a NOP.
    assign inst_o     = hit ? data_q : ZERO_WORD;
    assign stallreq_o = ((ce_i == CHIP_ENABLE) & ~hit) ? STOP : NO_STOP;
    assign if_busy_o  = (state_q == S_WAIT);

    // Strobes come straight from the state register so the SRAM never sees glitches.
    assign ram_ce_n_o = ~(state_q == S_WAIT);
    assign ram_oe_n_o = ~(state_q == S_WAIT);
    assign ram_addr_o = req_addr_q[ADDR_W-1:0];
    assign ram_we_n_o = 1'b1;
    assign ram_be_n_o = 4'b0000;

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: launch on an unblocked miss, return to idle when the count expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = S_WAIT;
            S_WAIT: if (done)   state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    // Read datapath: latch the request on launch, count down, capture and tag on completion.
    // A read already in flight finishes against its own address even if the pc moved.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q      <= 4'd0;
            req_addr_q <= 30'd0;
            tag_q      <= 30'd0;
            data_q     <= ZERO_WORD;
            valid_q    <= 1'b0;
        end else begin
            if (launch) begin
                req_addr_q <= pc_word;
                cnt_q      <= CNT_LOAD;
            end
            if (state_q == S_WAIT) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    data_q  <= ram_data_i;
                    tag_q   <= req_addr_q;
                    valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_sram.sv
module tb_inst_fetch_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        bus_busy_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        if_busy_o;
    logic [19:0] ram_addr_o;
    logic [31:0] ram_data_i;
    logic        ram_ce_n_o;
    logic        ram_oe_n_o;
    logic        ram_we_n_o;
    logic [3:0]  ram_be_n_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    inst_fetch_sram #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .bus_busy_i (bus_busy_i),
        .inst_o     (inst_o),
        .stallreq_o (stallreq_o),
        .if_busy_o  (if_busy_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_i (ram_data_i),
        .ram_ce_n_o (ram_ce_n_o),
        .ram_oe_n_o (ram_oe_n_o),
        .ram_we_n_o (ram_we_n_o),
        .ram_be_n_o (ram_be_n_o)
    );

    always #5 clk = ~clk;

    // SRAM contents: word 0 is 0x3401_0001, any other word a is {16'hC0DE, a[15:0]}.
    assign ram_data_i = (ram_addr_o == 20'd0) ? 32'h3401_0001 : {16'hC0DE, ram_addr_o[15:0]};

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; bus_busy_i = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        total_cnt++;
        if ({inst_o, stallreq_o, if_busy_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_be_n_o}
            !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000})
            $display("FAIL reset_outputs: inst=%h stall=%b busy=%b ce_n=%b oe_n=%b we_n=%b be_n=%b, want 0/0/0/1/1/1/0000",
                     inst_o, stallreq_o, if_busy_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_be_n_o);
        else pass_cnt++;
    endtask

    task automatic test_cold_miss();
        next_cycle();
        rst = 1'b0; ce_i = 1'b1; pc_i = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (c < 3) begin
                if ({stallreq_o, ram_ce_n_o, ram_oe_n_o, ram_addr_o} !== {1'b1, (c == 0), (c == 0), 20'h0})
                    $display("FAIL cold_miss_c%0d: stall=%b ce_n=%b oe_n=%b addr=%h, want 1/%b/%b/00000",
                             c, stallreq_o, ram_ce_n_o, ram_oe_n_o, ram_addr_o, c == 0, c == 0);
                else pass_cnt++;
            end else begin
                if ({inst_o, stallreq_o, ram_ce_n_o} !== {32'h3401_0001, 1'b0, 1'b1})
                    $display("FAIL cold_miss_done: inst=%h stall=%b ce_n=%b, want 34010001/0/1",
                             inst_o, stallreq_o, ram_ce_n_o);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_hit_held();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({inst_o, stallreq_o, ram_ce_n_o, if_busy_o} !== {32'h3401_0001, 1'b0, 1'b1, 1'b0})
                $display("FAIL hit_held_c%0d: inst=%h stall=%b ce_n=%b busy=%b, want 34010001/0/1/0",
                         c, inst_o, stallreq_o, ram_ce_n_o, if_busy_o);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs   [2] = '{32'h4, 32'h8};
        logic [19:0] addrs [2] = '{20'h1, 20'h2};
        logic [31:0] words [2] = '{32'hC0DE_0001, 32'hC0DE_0002};
        for (int k = 0; k < 2; k++) begin
            pc_i = pcs[k];
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                total_cnt++;
                if (c == 0) begin
                    if ({stallreq_o, ram_ce_n_o, inst_o} !== {1'b1, 1'b1, 32'h0})
                        $display("FAIL seq%0d_launch: stall=%b ce_n=%b inst=%h, want 1/1/0", k, stallreq_o, ram_ce_n_o, inst_o);
                    else pass_cnt++;
                end else if (c < 3) begin
                    if ({stallreq_o, ram_ce_n_o, if_busy_o, ram_addr_o} !== {1'b1, 1'b0, 1'b1, addrs[k]})
                        $display("FAIL seq%0d_wait%0d: stall=%b ce_n=%b busy=%b addr=%h, want 1/0/1/%h",
                                 k, c, stallreq_o, ram_ce_n_o, if_busy_o, ram_addr_o, addrs[k]);
                    else pass_cnt++;
                end else begin
                    if ({inst_o, stallreq_o} !== {words[k], 1'b0})
                        $display("FAIL seq%0d_done: inst=%h stall=%b, want %h/0", k, inst_o, stallreq_o, words[k]);
                    else pass_cnt++;
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_bus_busy();
        pc_i = 32'h10; bus_busy_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) bus_busy_i = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (c < 5) begin
                if ({stallreq_o, ram_ce_n_o, if_busy_o} !== {1'b1, 1'b1, 1'b0})
                    $display("FAIL busy_hold_c%0d: stall=%b ce_n=%b busy=%b, want 1/1/0", c, stallreq_o, ram_ce_n_o, if_busy_o);
                else pass_cnt++;
            end else if (c < 7) begin
                if ({ram_ce_n_o, ram_addr_o, stallreq_o} !== {1'b0, 20'h4, 1'b1})
                    $display("FAIL busy_wait_c%0d: ce_n=%b addr=%h stall=%b, want 0/00004/1", c, ram_ce_n_o, ram_addr_o, stallreq_o);
                else pass_cnt++;
            end else begin
                if ({inst_o, stallreq_o} !== {32'hC0DE_0004, 1'b0})
                    $display("FAIL busy_done: inst=%h stall=%b, want c0de0004/0", inst_o, stallreq_o);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_pc_change();
        pc_i = 32'h20;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) pc_i = 32'h40;
            @(negedge clk);
            total_cnt++;
            case (c)
                1, 2: begin
                    if ({ram_ce_n_o, ram_addr_o, inst_o, stallreq_o} !== {1'b0, 20'h8, 32'h0, 1'b1})
                        $display("FAIL pcchg_old_c%0d: ce_n=%b addr=%h inst=%h stall=%b, want 0/00008/0/1",
                                 c, ram_ce_n_o, ram_addr_o, inst_o, stallreq_o);
                    else pass_cnt++;
                end
                3: begin
                    if ({ram_ce_n_o, inst_o, stallreq_o} !== {1'b1, 32'h0, 1'b1})
                        $display("FAIL pcchg_remiss: ce_n=%b inst=%h stall=%b, want 1/0/1", ram_ce_n_o, inst_o, stallreq_o);
                    else pass_cnt++;
                end
                4, 5: begin
                    if ({ram_ce_n_o, ram_addr_o} !== {1'b0, 20'h10})
                        $display("FAIL pcchg_new_c%0d: ce_n=%b addr=%h, want 0/00010", c, ram_ce_n_o, ram_addr_o);
                    else pass_cnt++;
                end
                6: begin
                    if ({inst_o, stallreq_o} !== {32'hC0DE_0010, 1'b0})
                        $display("FAIL pcchg_done: inst=%h stall=%b, want c0de0010/0", inst_o, stallreq_o);
                    else pass_cnt++;
                end
                default: begin
                    if ({stallreq_o, ram_ce_n_o} !== {1'b1, 1'b1})
                        $display("FAIL pcchg_launch: stall=%b ce_n=%b, want 1/1", stallreq_o, ram_ce_n_o);
                    else pass_cnt++;
                end
            endcase
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        pc_i = 32'h80;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({ram_ce_n_o, if_busy_o} !== {1'b0, 1'b1})
            $display("FAIL rstwait_pre: ce_n=%b busy=%b, want 0/1", ram_ce_n_o, if_busy_o);
        else pass_cnt++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ram_ce_n_o, if_busy_o, stallreq_o, inst_o} !== {1'b1, 1'b0, 1'b1, 32'h0})
            $display("FAIL rstwait_post: ce_n=%b busy=%b stall=%b inst=%h, want 1/0/1/0",
                     ram_ce_n_o, if_busy_o, stallreq_o, inst_o);
        else pass_cnt++;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if ({inst_o, stallreq_o} !== {32'hC0DE_0020, 1'b0})
            $display("FAIL rstwait_refetch: inst=%h stall=%b, want c0de0020/0", inst_o, stallreq_o);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_ce_off();
        ce_i = 1'b0;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if ({inst_o, stallreq_o, ram_ce_n_o} !== {32'h0, 1'b0, 1'b1})
            $display("FAIL ce_off: inst=%h stall=%b ce_n=%b, want 0/0/1", inst_o, stallreq_o, ram_ce_n_o);
        else pass_cnt++;
        next_cycle();
        ce_i = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({inst_o, stallreq_o} !== {32'hC0DE_0020, 1'b0})
            $display("FAIL ce_on_retained: inst=%h stall=%b, want c0de0020/0", inst_o, stallreq_o);
        else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_held();
        test_sequential();
        test_bus_busy();
        test_pc_change();
        test_reset_mid_wait();
        test_ce_off();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
